ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  launch request from EX stage, sampled on rising clk.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  operand rs (multiplicand / dividend), taken from the ID/EX A output.
REQ-007 b  input  32  operand rt (multiplier / divisor), taken from the ID/EX B output.
REQ-008 flush  input  1  abort any operation in flight (branch/jump squash).
REQ-009 busy  output  1  high while an operation is in flight; pipeline stall request.
REQ-010 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-011 hi  output  32  HI register: product[63:32] or remainder.
REQ-012 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-014 IDLE->RUN when start=1 and flush=0; a, b and op are latched on that edge; the 6-bit counter clears.
REQ-015 RUN SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, on operand magnitudes, for exactly 32 cycles; then RUN->FIX.
REQ-016 FIX SHALL apply sign correction for signed ops: product negated if sign(a)^sign(b); quotient negated if sign(a)^sign(b); remainder takes the sign of a. FIX->DONE.
REQ-017 On the edge entering DONE, hi/lo SHALL update and done SHALL be 1 for exactly one cycle; DONE->IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the 34th cycle after the cycle in which start was sampled.
REQ-019 busy SHALL be 1 in RUN, FIX and DONE, and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 Back-to-back: start sampled in the cycle after done launches a new operation.
REQ-022 flush=1 in any state SHALL return the FSM to IDLE on the next edge, with hi/lo unchanged and no done pulse.
REQ-023 flush and start high in the same IDLE cycle: flush wins and nothing launches.
REQ-024 Divide by zero SHALL keep full latency and yield lo=32'hFFFFFFFF, hi=a.
REQ-025 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0.
REQ-026 hi/lo SHALL change only on DONE entry or reset.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0 and latched operands=0, including in mid-operation.
REQ-028 After rst_n deasserts, the first start is accepted on the first rising edge.

Configuration
REQ-029 Macro MULDIV_DIV_EN SHALL compile the divide datapath in.
REQ-030 With MULDIV_DIV_EN defined: DIV and DIVU behave per REQ-015..REQ-025.
REQ-031 Without MULDIV_DIV_EN: DIV/DIVU start is ignored (busy stays 0, no done, hi/lo unchanged); no divider logic is synthesized.

Structure
REQ-032 Package muldiv_pkg SHALL hold the op encodings, the FSM state typedef, the step count constant (32) and the counter width (6).
REQ-033 The per-cycle datapath step (add/subtract-shift of the 64-bit accumulator) SHALL be sub-module muldiv_step; FSM, counter and sign fix remain in ex_muldiv.

Verification
REQ-034 MULTU a=32'hFFFFFFFF b=2 -> done at cycle 34, hi=1, lo=32'hFFFFFFFE, busy 1 for cycles 1..34.
REQ-035 MULT a=-3 b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-036 DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=5 b=0 -> lo=32'hFFFFFFFF, hi=5.
REQ-037 MULTU 3x4, then MULT 2x2 with flush=1 at cycle 10 -> busy 0 at cycle 11, no done, hi=0, lo=12 retained.
REQ-038 rst_n pulsed low at cycle 20 of a DIVU -> busy, done, hi and lo at 0 immediately; a new start after release completes normally.
REQ-039 A second start at cycle 5 of an operation -> ignored; exactly one done pulse with the first operation's result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state encoding, step count and counter width, plus a small
// conditional-negate helper used for operand magnitudes and sign fix-up.
package muldiv_pkg;

    // Operation encodings on the op input.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state type and encodings.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // One datapath step per operand bit.
    localparam int STEP_COUNT = 32;
    localparam int CNT_W      = 6;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply/divide datapath on a 64-bit
// accumulator. Multiply: shift-add with the multiplier in the low half.
// Divide (only when MULDIV_DIV_EN is defined): restoring subtract-shift with
// the dividend entering from the low half and quotient bits shifted in at bit 0.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
`ifdef MULDIV_DIV_EN
    input  logic        is_div_i,
`endif
    output logic [63:0] acc_o
);

    logic [32:0] sum;
`ifdef MULDIV_DIV_EN
    logic [31:0] rem_sub;
`endif

    // Compute the next accumulator value for the selected operation.
    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set, then shift right keeping the carry.
        sum   = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
        acc_o = acc_i[0] ? {sum, acc_i[31:1]} : {1'b0, acc_i[63:1]};
`ifdef MULDIV_DIV_EN
        // Divide: the shifted partial remainder is acc_i[63:31]; when it
        // covers the divisor the 32-bit difference is exact because the
        // result is always below the divisor.
        rem_sub = acc_i[62:31] - opnd_i;
        if (is_div_i) begin
            if (acc_i[63:31] >= {1'b0, opnd_i}) begin
                acc_o = {rem_sub, acc_i[30:0], 1'b1};
            end else begin
                acc_o = {acc_i[62:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit producing MIPS-style HI/LO.
// FSM: IDLE -> RUN (32 steps) -> FIX (sign correction) -> DONE -> IDLE.
// Build option: define MULDIV_DIV_EN to include the divide datapath;
// without it DIV/DIVU requests are ignored.
//
// Handshake: start is sampled on a rising edge only while busy is low; an
// accepted start holds busy high until the cycle after the one-cycle done
// pulse. There is no queuing: start while busy is dropped. flush aborts
// anything in flight (and wins over start) without touching hi/lo.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d, step_acc;
    logic [31:0]      opnd_q, opnd_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             op_signed, op_is_div, launch;
    logic [31:0]      mag_a, mag_b;
    logic [63:0]      prod_fix;
    logic [31:0]      fix_hi, fix_lo;
`ifdef MULDIV_DIV_EN
    logic             div_q, div_d;
`endif

    // Decode the request and form operand magnitudes for the launch edge.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        mag_a     = cond_neg32(a, op_signed & a[31]);
        mag_b     = cond_neg32(b, op_signed & b[31]);
`ifdef MULDIV_DIV_EN
        launch    = start & ~flush;
`else
        launch    = start & ~flush & ~op_is_div;
`endif
    end

    muldiv_step u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
`ifdef MULDIV_DIV_EN
        .is_div_i (div_q),
`endif
        .acc_o    (step_acc)
    );

    // Sign correction of the raw magnitude result, evaluated during FIX.
    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
        if (div_q) begin
            // Quotient follows sign(a)^sign(b); remainder follows sign(a).
            fix_lo = cond_neg32(acc_q[31:0], sa_q ^ sb_q);
            fix_hi = cond_neg32(acc_q[63:32], sa_q);
            // Divide by zero: remainder already carries a, quotient is all ones.
            if (opnd_q == 32'd0) begin
                fix_lo = 32'hFFFF_FFFF;
            end
        end
`endif
    end

    // Next-state logic for the FSM, step counter, datapath and HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        div_d   = div_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    sa_d    = op_signed & a[31];
                    sb_d    = op_signed & b[31];
`ifdef MULDIV_DIV_EN
                    div_d   = op_is_div;
                    if (op_is_div) begin
                        acc_d  = {32'd0, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {32'd0, mag_b};
                        opnd_d = mag_a;
                    end
`else
                    acc_d   = {32'd0, mag_b};
                    opnd_d  = mag_a;
`endif
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEP_COUNT - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Squash: back to IDLE with HI/LO untouched and no done pulse.
        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table plus hand sequences for
// flush, ignored start, reset mid-operation and flush/start collision.
// Adapts DIV/DIVU expectations to whether MULDIV_DIV_EN is defined.
module tb_ex_muldiv;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;   // {hi, lo}
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    vec_t        vecs[20];

    ex_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic bit op_launches(input logic [1:0] o);
        return !((o == T_DIV) || (o == T_DIVU)) || DIV_EN;
    endfunction

    // Scoreboard: every done pulse pops one expected {hi,lo}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got done=1 hi=%h lo=%h required no done", hi, lo);
            end else begin
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    n_fail++;
                    $display("FAIL result: got %h required %h", {hi, lo}, e);
                end
            end
        end
    end

    // Driver: called at a negedge; drives start for one cycle, watches
    // latency and busy, then checks retained HI/LO in the following cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input string name);
        bit launches;
        int lat;
        int busy_bad;
        launches = op_launches(o);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (launches) begin
            exp_q.push_back(exp);
            model_hi = exp[63:32];
            model_lo = exp[31:0];
        end
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 34 && busy !== launches) busy_bad++;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), launches ? 64'd34 : 64'd0);
        check({name, "_busy"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
        check({name, "_hilo"}, {hi, lo}, {model_hi, model_lo});
    endtask

    initial begin
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic [31:0]        x;
        logic [31:0]        y;
        int                 n_done;
        int                 first_done;
        bit                 launches;

        n_checks = 0;
        n_fail   = 0;
        model_hi = '0;
        model_lo = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        a        = '0;
        b        = '0;

        vecs[0]  = '{T_MULTU, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE, "multu_max_x2"};
        vecs[1]  = '{T_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, "mult_neg3_x7"};
        vecs[2]  = '{T_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_minint_sq"};
        vecs[3]  = '{T_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "mult_neg1_sq"};
        vecs[4]  = '{T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max_sq"};
        vecs[5]  = '{T_MULT,  32'h12345678, 32'hFFFFFFFF, 64'hFFFFFFFF_EDCBA988, "mult_by_neg1"};
        vecs[6]  = '{T_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "div_neg7_2"};
        vecs[7]  = '{T_DIVU,  32'd5,        32'd0,        64'h00000005_FFFFFFFF, "divu_by_zero"};
        vecs[8]  = '{T_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_overflow"};
        vecs[9]  = '{T_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, "divu_100_7"};
        vecs[10] = '{T_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7_neg2"};
        vecs[11] = '{T_DIV,   32'hFFFFFFF8, 32'd0,        64'hFFFFFFF8_FFFFFFFF, "div_neg_by_zero"};
        vecs[12] = '{T_DIVU,  32'hFFFFFFFF, 32'd10,       64'h00000005_19999999, "divu_max_10"};
        vecs[13] = '{T_MULTU, 32'd0,        32'hDEADBEEF, 64'h00000000_00000000, "multu_zero"};
        for (int i = 14; i < 20; i++) begin
            x = $urandom;
            if (i % 3 == 0) begin
                y  = 32'($urandom_range(1, 1000));
                vecs[i] = '{T_DIVU, x, y, {x % y, x / y}, "rand_divu"};
            end else if (i % 3 == 1) begin
                y  = $urandom;
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                vecs[i] = '{T_MULT, x, y, 64'(sx * sy), "rand_mult"};
            end else begin
                y  = $urandom;
                vecs[i] = '{T_MULTU, x, y, {32'd0, x} * {32'd0, y}, "rand_multu"};
            end
        end

        // Reset state while held in reset across clock edges.
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // Release and launch on the very first edge; vectors run back-to-back.
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // Flush mid-operation: prior result must be retained, no done.
        run_op(T_MULTU, 32'd3, 32'd4, 64'd12, "multu_3_4");
        start = 1'b1;
        op    = T_MULT;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_c10", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_c11", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hilo", {hi, lo}, 64'd12);

        // Flush and start together in IDLE: nothing launches.
        start = 1'b1;
        flush = 1'b1;
        op    = T_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_start_hilo", {hi, lo}, 64'd12);

        // Second start at cycle 5 is ignored: one done, first op's result.
        start = 1'b1;
        op    = T_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        exp_q.push_back(64'd42);
        model_hi   = 32'd0;
        model_lo   = 32'd42;
        @(negedge clk);
        start      = 1'b0;
        n_done     = 0;
        first_done = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 5) begin
                start = 1'b1;
                op    = T_MULT;
                a     = 32'd100;
                b     = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
        end
        check("ignore_start_dones", 64'(n_done), 64'd1);
        check("ignore_start_latency", 64'(first_done), 64'd34);
        check("ignore_start_hilo", {hi, lo}, 64'd42);

        // Reset pulsed at cycle 20 of a DIVU: immediate clear, then recovery.
        launches = op_launches(T_DIVU);
        start = 1'b1;
        op    = T_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        if (launches) exp_q.push_back({32'd1, 32'd333});
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, {63'd0, launches});
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        #1;
        check("async_reset_busy", {63'd0, busy}, 64'd0);
        check("async_reset_done", {63'd0, done}, 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(T_MULTU, 32'd9, 32'd9, 64'd81, "after_reset");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
